// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT_W bits per clock, LSB digit first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | one digit per clock, partial result on s
//   DONE  | result held, out_valid high until out_ready
module serial_adder_n #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    generate
        if ((DIGIT_W < 1) || (DIGIT_W > WIDTH) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_param
            $error("serial_adder_n: WIDTH must be a multiple of DIGIT_W and 1 <= DIGIT_W <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH:0]     s_q, s_d;
    logic [DIGIT_W:0]   sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operands shift right one digit per CALC cycle, so the active digit is always at the bottom.
    assign sum = {1'b0, a_q[DIGIT_W-1:0]} + {1'b0, b_q[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ^ cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int k = 0; k < NDIG; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        s_d[k*DIGIT_W +: DIGIT_W] = sum[DIGIT_W-1:0];
                    end
                end
                carry_d = sum[DIGIT_W];
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    s_d[WIDTH] = sum[DIGIT_W];
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
                    ovf_d = a_q[DIGIT_W-1] ^ b_q[DIGIT_W-1] ^ sum[DIGIT_W-1] ^ sum[DIGIT_W];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n (WIDTH=8, DIGIT_W=2): directed cases, backpressure, reset mid-op and random ops
// against an arithmetic reference model.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] s;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder_n #(.WIDTH(8), .DIGIT_W(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_s(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic rc, input logic rsub);
        int r;
        if (!rsub) begin
            r = int'(ra) + int'(rb) + int'(rc);
            return 9'(r);
        end
        r = int'(ra) - int'(rb) - int'(rc);
        return {(r >= 0), 8'(r)};
    endfunction

    function automatic logic ref_ovf(input logic [7:0] ra, input logic [7:0] rb,
                                     input logic rc, input logic rsub);
        int sa, sb, r;
        sa = ra[7] ? int'(ra) - 256 : int'(ra);
        sb = rb[7] ? int'(rb) - 256 : int'(rb);
        r  = rsub ? sa - sb - int'(rc) : sa + sb + int'(rc);
        return (r > 127) || (r < -128);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check latency and result; release=0 leaves it parked in DONE.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic tsub, input int hold, input logic early_rdy,
                          input logic release_it);
        int n;
        logic [8:0] exp_s;
        exp_s = ref_s(ta, tb_, tc, tsub);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tc; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        out_ready = early_rdy;
        check({tag, "_in_ready_calc"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(ta, tb_, tc, tsub)));
`endif
        if (!early_rdy) begin
            repeat (hold) @(posedge clk);
            #1;
            check({tag, "_s_held"}, 32'(s), 32'(exp_s));
        end
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        run_op("add0",    8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_op("ripple",  8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        run_op("sub1",    8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        run_op("sub2",    8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        run_op("sub3",    8'h05, 8'h05, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        check("sub3_bit8", 32'(s[8]), 32'd0);

        // Backpressure: park in DONE while pulsing in_valid with other operands.
        run_op("bp", 8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk);
            #1;
            check("bp_s", 32'(s), 32'h046);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("bp_nothing_queued", 32'(out_valid), 32'd0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rmid_out_valid", 32'(out_valid), 32'd0);
        check("rmid_s", 32'(s), 32'd0);
        check("rmid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf1", 8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_op("ovf2", 8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        run_op("ovf3", 8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1);
`endif

        // Random operations, some with out_ready raised during CALC, some held in DONE.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            run_op("rand", ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the one-bit full adder. It processes DIGIT_W bits per clock, LSB digit first, with a registered carry between digits. It has a valid/ready handshake on input and output, so it can sit between streaming blocks in the datapath. It trades latency for area: one DIGIT_W-bit adder slice is reused for WIDTH/DIGIT_W cycles.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT_W (elaboration-time $error otherwise).
- DIGIT_W, 2, bits added per clock; 1 <= DIGIT_W <= WIDTH.
- NDIG (localparam), WIDTH/DIGIT_W, number of compute cycles.

Ports:
- clk  in  1  clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH+1  result; s[WIDTH] is carry-out (add) or not-borrow (sub).

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, s=0, internal carry=0, digit counter=0.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On an edge with in_valid&&in_ready:
  - latch a, b_eff = sub ? ~b : b, and c0 = sub ? ~cin : cin;
  - go to CALC with counter=0.
  - Inputs are sampled only at this edge; later changes are ignored.
- CALC: in_ready=0, out_valid=0. Each edge:
  - s[k*DIGIT_W +: DIGIT_W] = a_digit + b_eff_digit + carry, where k = counter;
  - carry <= carry-out of that digit; counter increments.
  - On the edge where counter == NDIG-1, write carry into s[WIDTH] and go to DONE.
- DONE: out_valid=1, s held stable, in_ready=0. On an edge with out_ready=1 go to IDLE. out_valid deasserts and in_ready asserts in the following cycle.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge. Minimum issue interval is NDIG+2 cycles.
- Arithmetic:
  - add: s = a + b + cin, (WIDTH+1) bits, unsigned.
  - sub: s[WIDTH-1:0] = a - b - cin mod 2^WIDTH; s[WIDTH] = 1 iff a >= b + cin (no borrow).
- s is stable from out_valid rising until the output handshake. Partial digits are visible on s during CALC and must not be used.
- in_valid while not in IDLE: ignored, nothing is queued.
- out_ready high before out_valid: no effect.
- DIGIT_W == WIDTH: NDIG=1; behaves as a single-cycle registered adder with one CALC cycle.
- resetn asserted in any state: immediate return to reset values; the in-flight operation is discarded.

Optional Feature:
SERIAL_ADDER_OVF_EN
- Defined: adds output port ovf (1 bit), registered and valid with out_valid. It is the signed two's-complement overflow: carry into the MSB XOR carry out of the MSB, taken from the final digit. It resets to 0 and is held in DONE.
- Undefined: no ovf port, no extra logic; behaviour otherwise identical.

Test Plan:
All scenarios use WIDTH=8, DIGIT_W=2 (NDIG=4).
1. Add basic: a=8'h00, b=8'h00, cin=0, sub=0 -> s=9'h000; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout CALC/DONE.
2. Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> s=9'h100. Then a=8'hFF, b=8'hFF, cin=1 -> s=9'h1FF.
3. Subtract: sub=1, a=8'h07, b=8'h05, cin=0 -> s=9'h102. Then sub=1, a=8'h05, b=8'h07, cin=0 -> s=9'h0FE (borrow, s[8]=0). Then sub=1, a=8'h05, b=8'h05, cin=1 -> s=9'h0FF.
4. Backpressure: complete a=8'h12 + b=8'h34, hold out_ready=0 for 10 cycles while pulsing in_valid with other operands -> s=9'h046 stable, out_valid=1, in_ready=0, pulses ignored. Release out_ready -> in_ready=1 the next cycle.
5. Reset mid-op: accept a=8'hAA, b=8'h55, assert resetn low after 2 CALC cycles -> out_valid=0, s=0, in_ready=1 immediately. After release, a=8'h10 + b=8'h20 -> s=9'h030.
6. With SERIAL_ADDER_OVF_EN: a=8'h7F + b=8'h01 -> s=9'h080, ovf=1. sub=1, a=8'h80, b=8'h01 -> s=9'h17F, ovf=1. a=8'h01 + b=8'h01 -> ovf=0.
